// File: rtl/mfp_pmod_als_spi_sampler_if.sv
// Signal bundle between the PmodALS SPI sampler, the ADC pins and the sample consumer.
interface mfp_pmod_als_spi_sampler_if;
  logic        enable;
  logic        cs;
  logic        sck;
  logic        sdo;
  logic [15:0] value;
  logic [7:0]  light;
  logic        frame_ok;
  logic        valid;

  modport master (
    input  enable, sdo,
    output cs, sck, value, light, frame_ok, valid
  );

  modport slave (
    output enable, sdo,
    input  cs, sck, value, light, frame_ok, valid
  );
endinterface

// File: rtl/mfp_pmod_als_spi_sampler.sv
// Periodic 16-bit SPI read of the PmodALS ADC081S021; publishes raw frame, light code and valid pulse.
//
// state | meaning
// GAP   | cs high, gap counter running (saturates), waits for enable
// SETUP | cs low, sck still high until the first fall
// SHIFT | 16 sck periods, sdo captured on every rising sck
// HOLD  | one half-period after the last rise, then cs rises with the result
module mfp_pmod_als_spi_sampler #(
  parameter int unsigned SCK_DIV    = 8,
  parameter int unsigned SAMPLE_GAP = 1000
) (
  input logic                        clock,
  input logic                        reset_n,
  mfp_pmod_als_spi_sampler_if.master bus
);

  typedef enum logic [1:0] {GAP, SETUP, SHIFT, HOLD} state_t;

  localparam logic [15:0] GAP_LAST = 16'(SAMPLE_GAP - 1);
  localparam logic [7:0]  DIV_LAST = 8'(SCK_DIV - 1);

  state_t      state, state_nxt;
  logic [15:0] gap_cnt;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic        cs_q, sck_q, valid_q, ok_q;
  logic [15:0] value_q;
  logic [7:0]  light_q;
  logic        tick, gap_done, last_rise;

  // Half-period down-counter: tick marks every SCK_DIV-th edge after cs falls.
  assign tick      = (div_cnt == 8'd0);
  assign gap_done  = (gap_cnt >= GAP_LAST);
  assign last_rise = tick && !sck_q && (bit_cnt == 4'd15);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= GAP;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GAP:     if (gap_done && bus.enable) state_nxt = SETUP;
      SETUP:   if (tick)                   state_nxt = SHIFT;
      SHIFT:   if (last_rise)              state_nxt = HOLD;
      HOLD:    if (tick)                   state_nxt = GAP;
      default:                             state_nxt = GAP;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_q      <= 1'b1;
      sck_q     <= 1'b1;
      gap_cnt   <= 16'd0;
      div_cnt   <= 8'd0;
      bit_cnt   <= 4'd0;
      shift_reg <= 16'd0;
      value_q   <= 16'd0;
      light_q   <= 8'd0;
      ok_q      <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state == GAP) begin
        if (gap_done && bus.enable) begin
          cs_q    <= 1'b0;
          div_cnt <= DIV_LAST;
          bit_cnt <= 4'd0;
        end else if (!gap_done) begin
          gap_cnt <= gap_cnt + 16'd1;
        end
      end else begin
        div_cnt <= tick ? DIV_LAST : div_cnt - 8'd1;
        if (tick) begin
          case (state)
            SETUP: sck_q <= 1'b0;
            SHIFT: begin
              if (!sck_q) begin
                // sdo has been settled for a full half-period here, so no synchroniser.
                sck_q     <= 1'b1;
                shift_reg <= {shift_reg[14:0], bus.sdo};
                bit_cnt   <= bit_cnt + 4'd1;
              end else begin
                sck_q <= 1'b0;
              end
            end
            HOLD: begin
              cs_q    <= 1'b1;
              gap_cnt <= 16'd0;
              value_q <= shift_reg;
              light_q <= shift_reg[12:5];
              ok_q    <= (shift_reg[15:13] == 3'b000);
              valid_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.cs       = cs_q;
  assign bus.sck      = sck_q;
  assign bus.value    = value_q;
  assign bus.light    = light_q;
  assign bus.frame_ok = ok_q;
  assign bus.valid    = valid_q;

endmodule

// File: tb/tb_mfp_pmod_als_spi_sampler.sv
// Bench for the PmodALS sampler: two instances (slow and fast timing) checked against a timeline model.
module tb_mfp_pmod_als_spi_sampler;
  localparam int D0 = 8, G0 = 1000, D1 = 2, G1 = 1;

  logic clock = 1'b0;
  logic rst0  = 1'b0;
  logic rst1  = 1'b0;
  always #5 clock = ~clock;

  mfp_pmod_als_spi_sampler_if if0();
  mfp_pmod_als_spi_sampler_if if1();

  mfp_pmod_als_spi_sampler #(.SCK_DIV(D0), .SAMPLE_GAP(G0)) dut0 (
    .clock(clock), .reset_n(rst0), .bus(if0.master));
  mfp_pmod_als_spi_sampler #(.SCK_DIV(D1), .SAMPLE_GAP(G1)) dut1 (
    .clock(clock), .reset_n(rst1), .bus(if1.master));

  int total = 0;
  int bad   = 0;

  // Timeline model: t = edges since cs fell, gap = edges spent with cs high.
  bit          in_frame [2];
  int          t        [2];
  int          gap      [2];
  logic [15:0] cur_frame[2];
  int          fall_idx [2];
  int          rises    [2];
  bit          exp_valid[2];
  logic [15:0] exp_value[2];
  bit          exp_ok   [2];

  logic [15:0] q0[$];
  logic [15:0] tbl1[5] = '{16'h0AE0, 16'hFFFF, 16'h1FE0, 16'h0000, 16'hA5C3};
  int          n1 = 0;

  function automatic int div_of(input int id);
    return (id == 0) ? D0 : D1;
  endfunction

  function automatic int gap_of(input int id);
    return (id == 0) ? G0 : G1;
  endfunction

  function automatic logic [15:0] next_frame(input int id);
    logic [15:0] f;
    if (id == 0) begin
      f = (q0.size() > 0) ? q0.pop_front() : 16'h0AE0;
    end else begin
      f  = tbl1[n1 % 5];
      n1 = n1 + 1;
    end
    return f;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, id, $time, act, exp);
    end
  endtask

  task automatic model_reset(input int id);
    in_frame[id]  = 1'b0;
    t[id]         = 0;
    gap[id]       = 0;
    exp_valid[id] = 1'b0;
    exp_value[id] = 16'h0000;
    exp_ok[id]    = 1'b0;
  endtask

  task automatic model_step(input int id, input logic en);
    exp_valid[id] = 1'b0;
    if (in_frame[id]) begin
      t[id]++;
      if (t[id] == 33 * div_of(id)) begin
        in_frame[id]  = 1'b0;
        gap[id]       = 0;
        exp_valid[id] = 1'b1;
        exp_value[id] = cur_frame[id];
        exp_ok[id]    = (cur_frame[id][15:13] == 3'b000);
      end
    end else if (gap[id] + 1 >= gap_of(id) && en) begin
      in_frame[id]  = 1'b1;
      t[id]         = 0;
      cur_frame[id] = next_frame(id);
      fall_idx[id]  = 0;
      rises[id]     = 0;
    end else if (gap[id] < gap_of(id)) begin
      gap[id]++;
    end
  endtask

  always @(posedge clock) begin
    if (!rst0) model_reset(0); else model_step(0, if0.enable);
    if (!rst1) model_reset(1); else model_step(1, if1.enable);
  end

  // ADC: next bit (MSB first) presented on each falling sck while selected.
  always @(negedge if0.sck) if (!if0.cs && fall_idx[0] < 16) begin
    if0.sdo = cur_frame[0][15 - fall_idx[0]];
    fall_idx[0]++;
  end
  always @(negedge if1.sck) if (!if1.cs && fall_idx[1] < 16) begin
    if1.sdo = cur_frame[1][15 - fall_idx[1]];
    fall_idx[1]++;
  end
  always @(posedge if0.sck) if (!if0.cs) rises[0]++;
  always @(posedge if1.sck) if (!if1.cs) rises[1]++;

  task automatic check_dut(input int id, input logic a_cs, input logic a_sck, input logic a_valid,
                           input logic [15:0] a_value, input logic [7:0] a_light, input logic a_ok);
    logic e_sck;
    e_sck = !in_frame[id] || (((t[id] / div_of(id)) % 2) == 0);
    chk("cs", id, a_cs, !in_frame[id]);
    chk("sck", id, a_sck, e_sck);
    chk("valid", id, a_valid, exp_valid[id]);
    chk("value", id, a_value, exp_value[id]);
    chk("light", id, a_light, exp_value[id][12:5]);
    chk("frame_ok", id, a_ok, exp_ok[id]);
    if (a_cs) chk("sck_idle", id, a_sck, 1);
    if (exp_valid[id]) chk("sck_rises", id, rises[id], 16);
  endtask

  always @(negedge clock) begin
    check_dut(0, if0.cs, if0.sck, if0.valid, if0.value, if0.light, if0.frame_ok);
    check_dut(1, if1.cs, if1.sck, if1.valid, if1.value, if1.light, if1.frame_ok);
  end

  // Fast instance: fixed 67-cycle valid period and 2-cycle sck phases inside every frame.
  int   cyc = 0, last_v1 = -1, run1 = 0;
  logic prev_cs1 = 1'b1, prev_sck1 = 1'b1;
  always @(negedge clock) begin
    cyc++;
    if (rst1) begin
      if (if1.valid) begin
        if (last_v1 >= 0) chk("valid_period", 1, cyc - last_v1, 67);
        last_v1 = cyc;
      end
      if (!if1.cs) begin
        if (prev_cs1)                 run1 = 1;
        else if (if1.sck == prev_sck1) run1++;
        else begin
          chk("sck_phase", 1, run1, 2);
          run1 = 1;
        end
      end else if (!prev_cs1) begin
        chk("sck_phase", 1, run1, 2);
      end
    end
    prev_cs1  = if1.cs;
    prev_sck1 = if1.sck;
  end

  task automatic wait_cs_fall(output int n);
    n = 0;
    while (if0.cs && n < 6000) begin
      @(posedge clock); #1;
      n++;
    end
    chk("cs_fall", 0, if0.cs, 0);
  endtask

  task automatic run_frame(output int low, output logic got);
    low = 1;
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clock); #1;
      if (if0.cs) begin
        got = if0.valid;
        break;
      end
      low++;
    end
    chk("frame_end", 0, if0.cs, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, low, idle_low;
    logic got;
    if0.enable = 1'b1;
    if1.enable = 1'b1;
    q0.push_back(16'h0AE0);
    q0.push_back(16'hFFFF);
    q0.push_back(16'h1FE0);
    q0.push_back(16'h0AE0);
    q0.push_back(16'h0AE0);
    q0.push_back(16'hFFFF);
    q0.push_back(16'h1020);

    repeat (5) @(posedge clock);
    #1;
    chk("rst_cs", 0, if0.cs, 1);
    chk("rst_sck", 0, if0.sck, 1);
    chk("rst_value", 0, if0.value, 16'h0000);
    chk("rst_valid", 0, if0.valid, 0);
    rst0 = 1'b1;
    rst1 = 1'b1;

    wait_cs_fall(n);
    chk("first_fall", 0, n, 1000);
    run_frame(low, got);
    chk("cs_low_len", 0, low, 264);
    chk("f1_valid", 0, got, 1);
    chk("f1_value", 0, if0.value, 16'h0AE0);
    chk("f1_light", 0, if0.light, 8'h57);
    chk("f1_ok", 0, if0.frame_ok, 1);

    wait_cs_fall(n);
    chk("gap_len", 0, n, 1000);
    run_frame(low, got);
    chk("f2_valid", 0, got, 1);
    chk("f2_value", 0, if0.value, 16'hFFFF);
    chk("f2_light", 0, if0.light, 8'hFF);
    chk("f2_ok", 0, if0.frame_ok, 0);

    wait_cs_fall(n);
    run_frame(low, got);
    chk("f3_value", 0, if0.value, 16'h1FE0);
    chk("f3_light", 0, if0.light, 8'hFF);
    chk("f3_ok", 0, if0.frame_ok, 1);

    // enable dropped mid-frame: the frame still completes, then the block idles
    wait_cs_fall(n);
    repeat (100) @(posedge clock);
    #1 if0.enable = 1'b0;
    run_frame(low, got);
    chk("drop_valid", 0, got, 1);
    chk("drop_value", 0, if0.value, 16'h0AE0);
    idle_low = 0;
    repeat (5000) begin
      @(posedge clock); #1;
      if (!if0.cs) idle_low++;
    end
    chk("idle_cs_low", 0, idle_low, 0);
    if0.enable = 1'b1;
    @(posedge clock); #1;
    chk("reen_cs", 0, if0.cs, 0);
    run_frame(low, got);
    chk("f5_value", 0, if0.value, 16'h0AE0);

    // reset in the middle of the next frame
    wait_cs_fall(n);
    repeat (150) @(posedge clock);
    #1;
    rst0 = 1'b0;
    model_reset(0);
    #1;
    chk("mid_rst_cs", 0, if0.cs, 1);
    chk("mid_rst_sck", 0, if0.sck, 1);
    chk("mid_rst_value", 0, if0.value, 16'h0000);
    chk("mid_rst_valid", 0, if0.valid, 0);
    repeat (3) @(posedge clock);
    #1 rst0 = 1'b1;
    wait_cs_fall(n);
    chk("post_rst_fall", 0, n, 1000);
    run_frame(low, got);
    chk("f7_valid", 0, got, 1);
    chk("f7_value", 0, if0.value, 16'h1020);
    chk("f7_light", 0, if0.light, 8'h81);
    chk("f7_ok", 0, if0.frame_ok, 1);

    repeat (20) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mfp_pmod_als_spi_sampler.md
Name: mfp_pmod_als_spi_sampler

Overview:
SPI master front end for the PmodALS light sensor (ADC081S021). It autonomously runs periodic 16-bit read frames on cs/sck, deserialises sdo MSB first, and presents the raw frame, the extracted 8-bit light code and a one-cycle valid strobe. It is the upstream producer that feeds the AHB-Lite ALS register read path. Its value output is bit-compatible with the 16-bit alsData word that path consumes.

Parameters:
SCK_DIV, 8, sck half-period in clock cycles; legal range 2..255.
SAMPLE_GAP, 1000, cycles cs is held high between frames; legal range 1..65535.

Ports:
clock  input  1  system clock (HCLK domain)
reset_n  input  1  asynchronous active-low reset
enable  input  1  1 = run periodic conversions; 0 = stop after the current frame
cs  output  1  SPI chip select, active low
sck  output  1  SPI clock, idles high
sdo  input  1  SPI serial data from the ADC
value  output  16  last complete raw frame, bit 15 = first bit received
light  output  8  value[12:5], the ADC data byte
frame_ok  output  1  1 when the last frame had value[15:13] == 3'b000
valid  output  1  one-cycle pulse when value, light and frame_ok update

Behaviour:
- Reset (asynchronous, any state): cs=1, sck=1, value=0, light=0, frame_ok=0, valid=0, all counters 0, state=GAP.
- Outputs are registered; there is no combinational path from sdo or enable to any output.
- FSM states: GAP, SETUP, SHIFT, HOLD.
- GAP: cs=1, sck=1; the gap counter runs. When the count reaches SAMPLE_GAP and enable=1 → SETUP, and cs falls on that edge. If enable=0, the counter saturates and the block waits.
- First frame after reset: cs falls SAMPLE_GAP cycles after reset_n deasserts, provided enable=1 throughout.
- Frame timing, with t=0 as the edge where cs falls:
  - sck falls at t=SCK_DIV.
  - sck rises at t=(2k+2)*SCK_DIV for bit k=0..15; sck falls between rises.
  - Last rise is at t=32*SCK_DIV.
  - cs rises at t=33*SCK_DIV, so cs is low for exactly 33*SCK_DIV cycles.
- SETUP lasts from t=0 to the first sck fall. SHIFT covers the 16 sck periods. HOLD lasts SCK_DIV cycles after the last rise.
- Sampling: on each clock edge that drives sck 0→1, sdo is shifted into bit 0 of a 16-bit shift register (shift left). No synchroniser is used; sdo has been stable for SCK_DIV cycles at that point.
- Exactly 16 bits are captured per frame. A bit counter of 0..15 is checked at the last rise.
- HOLD→GAP: on the same edge cs rises, the following update together and valid=1 for exactly that one cycle:
  - value ← shift register
  - light ← shift[12:5]
  - frame_ok ← (shift[15:13]==0)
- Between updates, value, light and frame_ok hold their last values.
- The gap counter restarts at 0 when cs rises, so the cs-high time between frames is exactly SAMPLE_GAP cycles.
- enable deasserted mid-frame: the frame completes normally, including the valid pulse, and the next frame does not start.
- enable reasserted during GAP: the gap must still reach SAMPLE_GAP before cs falls. If the counter is already saturated, cs falls on the next edge.
- Reset asserted mid-frame: cs and sck return to 1 immediately. The partial frame is discarded, with no valid pulse and no value update.
- Steady-state period (enable=1): 33*SCK_DIV + SAMPLE_GAP cycles between successive valid pulses.
- sck never toggles while cs=1.

Test Plan:
- Reset/idle: hold reset_n=0 with enable=1, then release → cs=1, sck=1, value=0, valid=0. With SCK_DIV=8 and SAMPLE_GAP=1000, cs falls exactly 1000 cycles after release.
- Single frame: an ADC model drives sdo on sck falling edges with frame 16'h0AE0 (leading 000, data 8'h57, trailing 00000) → after 264 cs-low cycles: value=16'h0AE0, light=8'h57, frame_ok=1, one valid pulse; bench counts 16 sck rising edges.
- Timing: SCK_DIV=2, SAMPLE_GAP=1 → cs low 66 cycles, sck high/low 2 cycles each, valid pulses every 67 cycles. Bench checks sck stays 1 while cs=1.
- Error flag: model sends 16'hFFFF → value=16'hFFFF, light=8'hFF, frame_ok=0. Next frame 16'h1FE0 → light=8'hFF, frame_ok=1.
- Enable control: drop enable at t=100 of a frame → that frame completes with valid. Cs then stays high indefinitely. Reassert enable after 5000 cycles → cs falls on the next edge.
- Reset mid-frame: assert reset_n=0 at t=150 of a frame that follows a frame of 16'h0AE0 → cs=1 and sck=1 asynchronously, value=0, no valid pulse. After release, the next frame starts SAMPLE_GAP cycles later and captures correctly.
